// File: rtl/pipelined_csa_adder.sv
// Pipelined carry-select adder/subtractor; one SEG-bit segment resolved per stage.
// Ports: clock, reset_n (async low); in_valid/in_ready, a, b, cin, sub;
// out_valid/out_ready, sum, cout, overflow (carry-into-MSB ^ cout).
module pipelined_csa_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NSEG = WIDTH / SEG;

    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             c0;
    logic [NSEG-1:0]  vld;

    // Whole pipe moves as one; no bubble collapsing.
    assign adv       = ~vld[NSEG-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[NSEG-1];

    // Subtract is a + ~b + 1; cin is ignored in that mode.
    assign bx = sub ? ~b : b;
    assign c0 = sub | cin;

    for (genvar k = 0; k < NSEG; k++) begin : g_st
        // HI: operand bits still unresolved after this stage.
        localparam int HI = WIDTH - (k + 1) * SEG;
        localparam int LW = (k + 1) * SEG;

        logic [SEG-1:0] sa;
        logic [SEG-1:0] sb;
        logic           ci;
        logic           v_d;
        logic           v_q;
        logic [SEG:0]   r;
        logic [LW-1:0]  s_d;
        logic [LW-1:0]  s_q;
        logic           c_q;

        if (k == 0) begin : g_src
            assign sa  = a[SEG-1:0];
            assign sb  = bx[SEG-1:0];
            assign ci  = c0;
            assign v_d = in_valid;
            assign r   = {1'b0, sa} + {1'b0, sb} + {{SEG{1'b0}}, ci};
            assign s_d = r[SEG-1:0];
        end else begin : g_src
            logic [SEG:0] r0;
            logic [SEG:0] r1;
            assign sa  = g_st[k-1].g_hi.a_q[SEG-1:0];
            assign sb  = g_st[k-1].g_hi.b_q[SEG-1:0];
            assign ci  = g_st[k-1].c_q;
            assign v_d = g_st[k-1].v_q;
            // Both carry hypotheses are ready before the carry arrives.
            assign r0  = {1'b0, sa} + {1'b0, sb};
            assign r1  = {1'b0, sa} + {1'b0, sb} + {{SEG{1'b0}}, 1'b1};
            assign r   = ci ? r1 : r0;
            assign s_d = {r[SEG-1:0], g_st[k-1].s_q};
        end

        assign vld[k] = v_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_d;
                s_q <= s_d;
                c_q <= r[SEG];
            end
        end

        if (HI > 0) begin : g_hi
            logic [HI-1:0] a_d;
            logic [HI-1:0] b_d;
            logic [HI-1:0] a_q;
            logic [HI-1:0] b_q;

            if (k == 0) begin : g_d
                assign a_d = a[WIDTH-1:SEG];
                assign b_d = bx[WIDTH-1:SEG];
            end else begin : g_d
                assign a_d = g_st[k-1].g_hi.a_q[HI+SEG-1:SEG];
                assign b_d = g_st[k-1].g_hi.b_q[HI+SEG-1:SEG];
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == NSEG - 1) begin : g_last
            logic ov_q;

            // Carry into the MSB is recovered from the MSB sum bit.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    ov_q <= 1'b0;
                end else if (adv) begin
                    ov_q <= r[SEG-1] ^ sa[SEG-1] ^ sb[SEG-1] ^ r[SEG];
                end
            end
        end
    end

    assign sum      = g_st[NSEG-1].s_q;
    assign cout     = g_st[NSEG-1].c_q;
    assign overflow = g_st[NSEG-1].g_last.ov_q;

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Testbench for pipelined_csa_adder: 32/16 directed table and sequences,
// plus 64/8 and 16/16 random sweeps, all checked through scoreboards.
module tb_pipelined_csa_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ov;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ov;
    } vec_t;

    typedef struct {
        res_t r;
        int   cyc;
        int   stl;
    } ent_t;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: wide unsigned sum for carry, exact signed sum for overflow.
    function automatic res_t model(input int w, input logic [63:0] x,
                                   input logic [63:0] y, input logic ci,
                                   input logic sb);
        logic [64:0]        m;
        logic [64:0]        ux;
        logic [64:0]        uy;
        logic [64:0]        u;
        logic signed [66:0] p;
        logic signed [66:0] sx;
        logic signed [66:0] sy;
        logic signed [66:0] s;
        res_t               r;
        m  = (65'd1 << w) - 65'd1;
        ux = {1'b0, x} & m;
        uy = {1'b0, y} & m;
        if (sb) u = ux + (~uy & m) + 65'd1;
        else    u = ux + uy + {64'd0, ci};
        r.sum  = u[63:0] & m[63:0];
        r.cout = u[w];
        p  = 67'sd1 <<< w;
        sx = $signed({2'b00, ux});
        sy = $signed({2'b00, uy});
        if (ux[w-1]) sx = sx - p;
        if (uy[w-1]) sy = sy - p;
        if (sb) s = sx - sy;
        else    s = sx + sy + $signed({66'd0, ci});
        r.ov = (s >= (p >>> 1)) || (s < -(p >>> 1));
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // ---------------- main 32/16 DUT ----------------
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;

    res_t cur;
    ent_t q[$];
    ent_t e;
    int   cyc = 0;
    int   stl = 0;
    int   nout = 0;
    int   lat;

    pipelined_csa_adder #(.WIDTH(32), .SEG(16)) dut (
        .clock(clk), .reset_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                nout++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stale%0d: out_valid with sum=%h, required none",
                             nout, sum);
                end else begin
                    e   = q.pop_front();
                    lat = cyc - e.cyc;
                    if (64'(sum) !== e.r.sum || cout !== e.r.cout ||
                        overflow !== e.r.ov || lat != 2 + stl - e.stl) begin
                        errors++;
                        $display("FAIL out%0d: sum=%h cout=%b ov=%b lat=%0d, required sum=%h cout=%b ov=%b lat=%0d",
                                 nout, sum, cout, overflow, lat,
                                 e.r.sum[31:0], e.r.cout, e.r.ov, 2 + stl - e.stl);
                    end
                end
            end
            if (out_valid && !out_ready) stl++;
            if (in_valid && in_ready) q.push_back('{cur, cyc, stl});
        end
    end

    task automatic drive(input logic [31:0] x, input logic [31:0] y,
                         input logic ci, input logic sb, input res_t ex);
        @(posedge clk);
        #1;
        a = x;
        b = y;
        cin = ci;
        sub = sb;
        cur = ex;
        in_valid = 1'b1;
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 60 && q.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        chk(nm, 64'(q.size()), 64'd0);
    endtask

    // ---------------- sweep DUTs ----------------
    logic srst_n = 1'b0;
    initial #12 srst_n = 1'b1;

    for (genvar g = 0; g < 2; g++) begin : g_sw
        localparam int W = (g == 0) ? 64 : 16;
        localparam int S = (g == 0) ? 8 : 16;
        localparam int N = W / S;

        logic         iv = 1'b0;
        logic         ir;
        logic         ov;
        logic         orr = 1'b0;
        logic         ci = 1'b0;
        logic         sb = 1'b0;
        logic         co;
        logic         of;
        logic [W-1:0] av = '0;
        logic [W-1:0] bv = '0;
        logic [W-1:0] sm;
        ent_t         sq[$];
        ent_t         se;
        int           sc = 0;
        int           ss = 0;
        int           nacc = 0;
        int           sl;
        logic         done = 1'b0;

        pipelined_csa_adder #(.WIDTH(W), .SEG(S)) u_sw (
            .clock(clk), .reset_n(srst_n),
            .in_valid(iv), .in_ready(ir),
            .a(av), .b(bv), .cin(ci), .sub(sb),
            .out_valid(ov), .out_ready(orr),
            .sum(sm), .cout(co), .overflow(of)
        );

        always @(negedge clk) begin
            sc++;
            if (srst_n) begin
                if (ov && orr) begin
                    checks++;
                    if (sq.size() == 0) begin
                        errors++;
                        $display("FAIL sweep%0d stale: sum=%h, required none", W, sm);
                    end else begin
                        se = sq.pop_front();
                        sl = sc - se.cyc;
                        if (64'(sm) !== se.r.sum || co !== se.r.cout ||
                            of !== se.r.ov || sl != N + ss - se.stl) begin
                            errors++;
                            $display("FAIL sweep%0d: sum=%h cout=%b ov=%b lat=%0d, required sum=%h cout=%b ov=%b lat=%0d",
                                     W, sm, co, of, sl, se.r.sum, se.r.cout,
                                     se.r.ov, N + ss - se.stl);
                        end
                    end
                end
                if (ov && !orr) ss++;
                if (iv && ir) begin
                    sq.push_back('{model(W, 64'(av), 64'(bv), ci, sb), sc, ss});
                    nacc++;
                end
            end
        end

        initial begin
            wait (srst_n);
            for (int c = 0; c < 3000 && nacc < 80; c++) begin
                @(posedge clk);
                #1;
                iv = ($urandom_range(0, 3) != 0);
                av = W'({$urandom, $urandom});
                bv = W'({$urandom, $urandom});
                if ($urandom_range(0, 4) == 0) bv = ~av;
                if ($urandom_range(0, 6) == 0) av = {1'b0, {(W-1){1'b1}}};
                ci  = 1'($urandom_range(0, 1));
                sb  = 1'($urandom_range(0, 1));
                orr = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk);
            #1;
            iv  = 1'b0;
            orr = 1'b1;
            for (int c = 0; c < 60 && sq.size() != 0; c++) @(negedge clk);
            checks++;
            if (nacc < 80 || sq.size() != 0) begin
                errors++;
                $display("FAIL sweep%0d drain: accepted=%0d left=%0d, required 80 and 0",
                         W, nacc, sq.size());
            end
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    vec_t        tab[12];
    logic [31:0] ra[8];
    logic [31:0] rb[8];
    logic        rc[8];
    logic        rs[8];
    logic [31:0] hs;
    logic        hc;
    logic        ho;
    int          idx;
    int          c;

    initial begin
        tab[0]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
        tab[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tab[2]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tab[3]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tab[4]  = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tab[5]  = '{32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
        tab[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
        tab[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tab[8]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        tab[9]  = '{32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0};
        tab[10] = '{32'h7FFF0000, 32'h00010000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tab[11] = '{32'h00008000, 32'h00008000, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        cur = '0;

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors back-to-back at full rate.
        for (int i = 0; i < 12; i++)
            drive(tab[i].a, tab[i].b, tab[i].cin, tab[i].sub,
                  '{64'(tab[i].sum), tab[i].cout, tab[i].ov});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("table_drain");

        // Eight ops with a 3-cycle consumer stall in the middle.
        for (int i = 0; i < 8; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
            rc[i] = 1'($urandom_range(0, 1));
            rs[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        c = 0;
        while (idx < 8 && c < 100) begin
            @(posedge clk);
            #1;
            out_ready = !(c >= 4 && c <= 6);
            a = ra[idx];
            b = rb[idx];
            cin = rc[idx];
            sub = rs[idx];
            cur = model(32, 64'(ra[idx]), 64'(rb[idx]), rc[idx], rs[idx]);
            in_valid = 1'b1;
            @(negedge clk);
            if (!out_ready) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                if (c == 4) begin
                    hs = sum;
                    hc = cout;
                    ho = overflow;
                end else begin
                    chk("stall_hold", {31'd0, cout, overflow, sum},
                        {31'd0, hc, ho, hs});
                end
            end
            if (in_ready) idx++;
            c++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("stream_drain");

        // Reset with results in flight.
        for (int i = 0; i < 3; i++) begin
            ra[0] = $urandom;
            rb[0] = $urandom;
            drive(ra[0], rb[0], 1'b0, 1'b0, model(32, 64'(ra[0]), 64'(rb[0]), 1'b0, 1'b0));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_sum", 64'(sum), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 64'd0);
        end

        for (int k = 0; k < 6000 && !(g_sw[0].done && g_sw[1].done); k++)
            @(negedge clk);
        chk("sweeps_done", 64'(g_sw[0].done & g_sw[1].done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
